comparator_sequencer: RTL and testbench

Controller that sequences the threshold comparator in the STFT binarization path. It accepts the upstream magnitude stream and drives the comparator's enable, clear, stage and threshold-address inputs. It collects the comparator's 1-bit decisions and packs them into words for the downstream binary feature buffer. It sits between the STFT magnitude stage and the comparator, and processes NUM_STAGE frames per start command.

---
 rtl/comparator_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_comparator_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_sequencer.sv
// Sequences the STFT threshold comparator and packs its 1-bit decisions into words.
// Optional COMPARATOR_SEQ_POPCNT_EN adds oPOPCNT, a per-frame count of 1 decisions.
module comparator_sequencer #(
    parameter int IL        = 10,
    parameter int FRAME_LEN = 8192,
    parameter int NUM_STAGE = 5,
    parameter int PACK_W    = 32
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iSTART,
    input  logic              iVALID,
    input  logic [IL-1:0]     iDATA,
    output logic              oREADY,
    output logic              oCMP_EN,
    output logic [IL-1:0]     oCMP_DATA,
    output logic [16:0]       oCMP_CNT,
    output logic [2:0]        oCMP_STAGE,
    output logic              oCMP_CLR,
    input  logic              iCMP_BIT,
    output logic [PACK_W-1:0] oWORD,
    output logic              oWORD_VALID,
    input  logic              iWORD_READY,
    output logic              oFRAME_DONE,
`ifdef COMPARATOR_SEQ_POPCNT_EN
    output logic [17:0]       oPOPCNT,
`endif
    output logic              oBUSY
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam int              CW         = $clog2(PACK_W + 1);
    localparam logic [CW-1:0]   PACK_FULL  = CW'(PACK_W);
    localparam logic [16:0]     LAST_CNT   = 17'(FRAME_LEN - 1);
    localparam logic [2:0]      LAST_STAGE = 3'(NUM_STAGE - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [16:0]       cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              en_q;
    logic [PACK_W-1:0] pack_q, pack_d;
    logic [CW-1:0]     pcnt_q, pcnt_d;
    logic [PACK_W-1:0] word_q, word_d;
    logic              wvalid_q, wvalid_d;

    logic out_free;
    logic flush_last;
    logic move;
    logic xfer;
    logic frame_done;

    // Pack/output path: a full (or final partial) pack moves out while the in-flight bit lands in the fresh pack.
    always_comb begin
        out_free   = !wvalid_q || iWORD_READY;
        flush_last = (state_q == S_FLUSH) && !en_q && (pcnt_q != '0);
        move       = ((pcnt_q == PACK_FULL) || flush_last) && out_free;

        pack_d   = pack_q;
        pcnt_d   = pcnt_q;
        word_d   = word_q;
        wvalid_d = wvalid_q && !iWORD_READY;

        if (move) begin
            word_d   = pack_q;
            wvalid_d = 1'b1;
            pack_d   = '0;
            pcnt_d   = '0;
        end
        if (en_q) begin
            pack_d = pack_d | (PACK_W'(iCMP_BIT) << pcnt_d);
            pcnt_d = pcnt_d + CW'(1);
        end
    end

    // Accept only if the bit issued now is guaranteed a slot when it returns next cycle.
    assign oREADY     = (state_q == S_RUN) && ((pcnt_d < PACK_FULL) || !wvalid_d);
    assign xfer       = iVALID && oREADY;
    assign frame_done = (state_q == S_FLUSH) && !en_q && (pcnt_q == '0) && !wvalid_q;

    assign oCMP_EN     = xfer;
    assign oCMP_DATA   = xfer ? iDATA : '0;
    assign oCMP_CNT    = cnt_q;
    assign oCMP_STAGE  = stage_q;
    assign oCMP_CLR    = (state_q == S_CLEAR);
    assign oWORD       = word_q;
    assign oWORD_VALID = wvalid_q;
    assign oFRAME_DONE = frame_done;
    assign oBUSY       = busy_q;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    state_d = S_CLEAR;
                    stage_d = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (xfer) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FLUSH;
                    end else begin
                        cnt_d = cnt_q + 17'd1;
                    end
                end
            end
            default: begin
                if (frame_done) begin
                    if (stage_q < LAST_STAGE) begin
                        stage_d = stage_q + 3'd1;
                        state_d = S_CLEAR;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q  <= S_IDLE;
            stage_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            pack_q   <= '0;
            pcnt_q   <= '0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            en_q     <= xfer;
            pack_q   <= pack_d;
            pcnt_q   <= pcnt_d;
            word_q   <= word_d;
            wvalid_q <= wvalid_d;
        end
    end

`ifdef COMPARATOR_SEQ_POPCNT_EN
    logic [17:0] pop_q, pop_d;

    always_comb begin
        pop_d = pop_q;
        if (state_q == S_CLEAR) begin
            pop_d = '0;
        end else if (en_q && iCMP_BIT) begin
            pop_d = pop_q + 18'd1;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop_d;
        end
    end

    assign oPOPCNT = pop_q;
`endif

endmodule

// File: tb/tb_comparator_sequencer.sv
// Randomized bench for comparator_sequencer; expected words and per-frame results come from
// a per-pixel decision table packed with plain arithmetic.
module tb_comparator_sequencer;

    localparam int IL        = 10;
    localparam int FRAME_LEN = 10;
    localparam int NUM_STAGE = 2;
    localparam int PACK_W    = 4;
    localparam int WPF       = (FRAME_LEN + PACK_W - 1) / PACK_W;

    logic              iCLK = 1'b0;
    logic              iRSTn;
    logic              iSTART;
    logic              iVALID;
    logic [IL-1:0]     iDATA;
    logic              oREADY;
    logic              oCMP_EN;
    logic [IL-1:0]     oCMP_DATA;
    logic [16:0]       oCMP_CNT;
    logic [2:0]        oCMP_STAGE;
    logic              oCMP_CLR;
    logic              iCMP_BIT;
    logic [PACK_W-1:0] oWORD;
    logic              oWORD_VALID;
    logic              iWORD_READY;
    logic              oFRAME_DONE;
    logic              oBUSY;
`ifdef COMPARATOR_SEQ_POPCNT_EN
    logic [17:0]       oPOPCNT;
`endif

    comparator_sequencer #(
        .IL        (IL),
        .FRAME_LEN (FRAME_LEN),
        .NUM_STAGE (NUM_STAGE),
        .PACK_W    (PACK_W)
    ) dut (
        .iCLK        (iCLK),
        .iRSTn       (iRSTn),
        .iSTART      (iSTART),
        .iVALID      (iVALID),
        .iDATA       (iDATA),
        .oREADY      (oREADY),
        .oCMP_EN     (oCMP_EN),
        .oCMP_DATA   (oCMP_DATA),
        .oCMP_CNT    (oCMP_CNT),
        .oCMP_STAGE  (oCMP_STAGE),
        .oCMP_CLR    (oCMP_CLR),
        .iCMP_BIT    (iCMP_BIT),
        .oWORD       (oWORD),
        .oWORD_VALID (oWORD_VALID),
        .iWORD_READY (iWORD_READY),
        .oFRAME_DONE (oFRAME_DONE),
`ifdef COMPARATOR_SEQ_POPCNT_EN
        .oPOPCNT     (oPOPCNT),
`endif
        .oBUSY       (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    bit                bits_t [NUM_STAGE][FRAME_LEN];
    logic [PACK_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ready",  oREADY,      0);
        check("rst_en",     oCMP_EN,     0);
        check("rst_data",   oCMP_DATA,   0);
        check("rst_cnt",    oCMP_CNT,    0);
        check("rst_stage",  oCMP_STAGE,  0);
        check("rst_clr",    oCMP_CLR,    0);
        check("rst_word",   oWORD,       0);
        check("rst_wvalid", oWORD_VALID, 0);
        check("rst_done",   oFRAME_DONE, 0);
        check("rst_busy",   oBUSY,       0);
`ifdef COMPARATOR_SEQ_POPCNT_EN
        check("rst_popcnt", oPOPCNT,     0);
`endif
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 ready, 1 20-cycle stall, 2 random.
    // bmode: 0 odd-pixel decisions, 1 random decisions. abort_at >= 0 resets at that pixel.
    task automatic run(input int vmode, input int rmode, input int bmode, input int abort_at);
        int frames = 0, pix = 0, issued = 0, acc = 0, wf = 0, clr = 0, pop = 0;
        bit pend = 0, pbit = 0, finished = 0;
        logic [PACK_W-1:0] w;

        for (int s = 0; s < NUM_STAGE; s++)
            for (int p = 0; p < FRAME_LEN; p++)
                bits_t[s][p] = (bmode != 0) ? 1'($urandom_range(0, 1)) : 1'(p % 2);
        exp_q.delete();
        for (int s = 0; s < NUM_STAGE; s++) begin
            for (int wi = 0; wi < WPF; wi++) begin
                w = '0;
                for (int i = 0; i < PACK_W; i++)
                    if (wi * PACK_W + i < FRAME_LEN) w[i] = bits_t[s][wi * PACK_W + i];
                exp_q.push_back(w);
            end
        end

        @(negedge iCLK);
        iSTART = 1'b1;
        iVALID = 1'b0;
        iWORD_READY = 1'b1;
        #1;
        check("idle_no_clr", oCMP_CLR, 0);

        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge iCLK);
            iCMP_BIT = pend ? pbit : 1'($urandom);
            pend = 0;
            iSTART = (vmode == 2 && frames < NUM_STAGE && cyc > 0) ? ($urandom_range(0, 15) == 0) : 1'b0;
            case (vmode)
                0:       iVALID = 1'b1;
                1:       iVALID = (cyc % 2) == 1;
                default: iVALID = 1'($urandom_range(0, 1));
            endcase
            iDATA = IL'($urandom);
            case (rmode)
                0:       iWORD_READY = 1'b1;
                1:       iWORD_READY = !(cyc >= 8 && cyc < 28);
                default: iWORD_READY = $urandom_range(0, 2) != 0;
            endcase
            #1;
            if (frames == NUM_STAGE) begin
                check("busy_drop", oBUSY, 0);
                finished = 1;
            end else begin
                if (cyc == 0) begin
                    check("clr_after_start", oCMP_CLR, 1);
                    check("ready_in_clear", oREADY, 0);
                end
                if (cyc == 1) check("ready_after_clear", oREADY, 1);
                check("busy_in_run", oBUSY, 1);
                check("en_follows_xfer", oCMP_EN, iVALID && oREADY);
                if (oWORD_VALID && iWORD_READY) begin
                    if (exp_q.size() == 0) check("unexpected_word", oWORD_VALID, 0);
                    else check("word", oWORD, exp_q.pop_front());
                    acc++;
                    wf++;
                end
                if (oCMP_EN) begin
                    check("cmp_cnt", oCMP_CNT, pix);
                    check("cmp_stage", oCMP_STAGE, frames);
                    check("cmp_data", oCMP_DATA, iDATA);
                    issued++;
                    check("backpressure_bound", (issued - PACK_W * acc) <= 2 * PACK_W, 1);
                    pbit = (pix < FRAME_LEN) ? bits_t[frames][pix] : 1'b0;
                    pend = 1;
                    pop += int'(pbit);
                    if (pix == abort_at) begin
                        iRSTn = 1'b0;
                        #1;
                        check_reset_outputs();
                        repeat (3) @(negedge iCLK);
                        iVALID = 1'b0;
                        iRSTn = 1'b1;
                        finished = 1;
                    end
                    pix++;
                end
                if (oCMP_CLR) begin
                    clr++;
                    check("clr_stage", oCMP_STAGE, frames);
                    check("clr_ready", oREADY, 0);
                end
                if (oFRAME_DONE && !finished) begin
                    check("frame_pixels", pix, FRAME_LEN);
                    check("frame_words", wf, WPF);
                    check("done_stage", oCMP_STAGE, frames);
`ifdef COMPARATOR_SEQ_POPCNT_EN
                    check("popcnt", oPOPCNT, pop);
`endif
                    frames++;
                    pix = 0; issued = 0; acc = 0; wf = 0; pop = 0;
                end
            end
        end

        if (abort_at < 0) begin
            check("run_finished", finished, 1);
            check("clr_count", clr, NUM_STAGE);
            check("words_left", exp_q.size(), 0);
        end
    endtask

    initial begin
        iRSTn = 1'b0;
        iSTART = 1'b0;
        iVALID = 1'b0;
        iDATA = '0;
        iCMP_BIT = 1'b0;
        iWORD_READY = 1'b1;
        repeat (3) @(negedge iCLK);
        check_reset_outputs();
        iRSTn = 1'b1;

        run(0, 0, 0, -1);
        run(0, 1, 0, -1);
        run(1, 0, 0, -1);
        repeat (4) run(2, 2, 1, -1);
        run(0, 0, 0, 5);
        run(0, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
